packet_arbiter_sv: RTL and testbench
====================================

Name: packet_arbiter_sv

Overview:
Two-source, packet-granular round-robin arbiter that shares one downstream 192-bit AXIS sample-word serializer between two ADC capture streams. It locks a grant for exactly PACKET_COUNT accepted beats and generates tlast on the final beat. It releases the grant on packet completion or on a stall timeout. It also provides per-source packet counters and sticky error flags for debug readout.

Parameters:
TDATA_WIDTH, 192, width of every AXIS data bus (12 x 16-bit samples)
PACKET_COUNT, 512, beats per granted packet; must be >= 2
TIMEOUT_CYCLES, 1024, cycles with no accepted beat while granted before abort; must be >= 2

Ports:
axis_aclk  in  1  single clock for all logic
axis_areset  in  1  reset, asynchronous, active-high
enable  in  1  allows new grants; does not affect a packet in progress
s00_axis_tvalid  in  1  source 0 valid
s00_axis_tdata  in  TDATA_WIDTH  source 0 data
s00_axis_tlast  in  1  source 0 last (checked only, never forwarded)
s00_axis_tready  out  1  source 0 ready
s01_axis_tvalid  in  1  source 1 valid
s01_axis_tdata  in  TDATA_WIDTH  source 1 data
s01_axis_tlast  in  1  source 1 last (checked only)
s01_axis_tready  out  1  source 1 ready
m00_axis_tvalid  out  1  to serializer
m00_axis_tdata  out  TDATA_WIDTH  to serializer
m00_axis_tlast  out  1  high on beat PACKET_COUNT-1 of a grant
m00_axis_tready  in  1  from serializer
grant  out  2  one-hot current owner; 2'b00 when idle
pkt_count0  out  16  completed packets from source 0, wraps at 2^16
pkt_count1  out  16  completed packets from source 1, wraps
err_tlast  out  1  sticky: source tlast disagreed with the generated tlast
err_timeout  out  1  sticky: a grant was aborted by timeout

Behaviour:
- Reset (async assert, sync release): state IDLE, grant 0, last_served = 1 (source 0 wins first), beat_cnt 0, stall_cnt 0, counters 0, error flags 0. All outputs are low or zero during reset.
- States are IDLE, OWN0 and OWN1. grant, beat_cnt, stall_cnt and last_served are registered.
- IDLE: both s0x_tready are 0 and m00_axis_tvalid is 0.
  - enable && exactly one source valid -> OWN of that source.
  - Both valid -> OWN of the source != last_served.
  - None valid or !enable -> stay in IDLE.
  - Grant latency is 1 cycle. No beat passes in the IDLE cycle.
- OWNn datapath is a combinational pass-through:
  - m00_axis_tvalid = s0n_tvalid; m00_axis_tdata = s0n_tdata.
  - s0n_tready = m00_axis_tready; the other source's tready = 0.
  - m00_axis_tdata = 0 whenever grant == 0.
- Beat accepted = m00_axis_tvalid && m00_axis_tready.
  - Each accepted beat increments beat_cnt.
  - m00_axis_tlast = granted && beat_cnt == PACKET_COUNT-1. It is combinational from the registered count.
- Packet completion: on the accepted beat with tlast high:
  - beat_cnt <= 0; pkt_countn += 1; last_served <= n.
  - Next state is IDLE. A re-arbitration cycle is always inserted, so back-to-back packets have a 1-cycle bubble.
- tlast check, on each accepted beat:
  - s0n_tlast != m00_axis_tlast -> err_tlast <= 1.
  - The beat is still forwarded and the count still advances; the generated tlast governs.
- Timeout:
  - stall_cnt clears on any accepted beat or on entering OWN; otherwise it increments.
  - When stall_cnt == TIMEOUT_CYCLES-1 with no accept that cycle: next state IDLE, beat_cnt <= 0, last_served <= n, err_timeout <= 1, pkt_count unchanged.
  - The downstream packet is left truncated with no tlast; the serializer must be reset by software.
- Simultaneous events: accept on the final beat in the same cycle as the timeout threshold -> completion wins and err_timeout is unchanged.
- Source deasserts tvalid mid-packet: the grant is held, with no switching, until completion or timeout.
- enable deasserted mid-packet: the packet completes normally; the arbiter then stays in IDLE.
- Reset mid-packet: immediate return to reset values. Downstream sees tvalid drop asynchronously.
- Counters wrap modulo 2^16 without saturation. Error flags clear only on reset.

Decomposition:
- Package packet_arbiter_pkg holds:
  - typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t.
  - constant PKT_CNT_W = 16.
  - function next_owner(valid[1:0], last_served), returning the round-robin choice.
- One natural sub-module, stall_timer: a counter with clear, enable and threshold-hit output, parameterised by TIMEOUT_CYCLES.
- Everything else stays in the top.

Test Plan:
- Only source 0 valid, downstream always ready, PACKET_COUNT=4:
  - grant=01 at cycle 1.
  - 4 beats forwarded, tlast on beat 3.
  - pkt_count0=1, then IDLE, then a new grant in the next cycle.
- Both sources continuously valid, PACKET_COUNT=4:
  - Grants alternate 01,10,01,10 with a 1-cycle idle gap between packets.
  - After 4 packets pkt_count0=2 and pkt_count1=2.
- Downstream tready toggling 1010…:
  - Data is forwarded unchanged in order; the other source's tready stays 0.
  - tlast is on the 4th accepted beat only.
- Source 1 asserts tlast on beat 1 of 4 -> err_tlast=1, the packet still completes at beat 3, pkt_count1 increments.
- Source 0 granted, sends 2 beats, then tvalid=0 for TIMEOUT_CYCLES=8 cycles:
  - err_timeout=1, grant drops to 00 at the 8th stall cycle, pkt_count0 unchanged.
  - The next packet is granted to source 1 if it is valid.
- Assert axis_areset mid-packet (beat 2) -> all outputs 0 immediately. After release, source 0 wins the first grant again.

Source files
------------

// File: rtl/packet_arbiter_pkg.sv
// packet_arbiter_pkg: shared types, widths and round-robin choice for packet_arbiter_sv
package packet_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
  localparam int PKT_CNT_W = 16;
  // returns 1 when source 1 should own next; on contention the source not served last wins
  function automatic logic next_owner(input logic [1:0] valid, input logic last_served);
    return (&valid) ? ~last_served : valid[1];
  endfunction
endpackage

// File: rtl/packet_arbiter_sv_stall_timer.sv
// stall_timer: counts idle cycles of a grant and flags the abort threshold
// clk/rst: clock, async active-high reset; clr: restart at 0; en: count this cycle
// hit: count has reached TIMEOUT_CYCLES-1
module stall_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);
  localparam int W = $clog2(TIMEOUT_CYCLES);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + W'(1);
  assign hit = cnt == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/packet_arbiter_sv.sv
// packet_arbiter_sv: packet-granular round-robin arbiter of two AXIS sources onto one sink
// s00/s01: source streams (tlast only checked); m00: sink stream with generated tlast
// grant: one-hot owner; pkt_count0/1: completed packets; err_tlast/err_timeout: sticky flags
module packet_arbiter_sv
  import packet_arbiter_pkg::*;
#(
  parameter int TDATA_WIDTH    = 192,
  parameter int PACKET_COUNT   = 512,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   axis_aclk,
  input  logic                   axis_areset,
  input  logic                   enable,
  input  logic                   s00_axis_tvalid,
  input  logic [TDATA_WIDTH-1:0] s00_axis_tdata,
  input  logic                   s00_axis_tlast,
  output logic                   s00_axis_tready,
  input  logic                   s01_axis_tvalid,
  input  logic [TDATA_WIDTH-1:0] s01_axis_tdata,
  input  logic                   s01_axis_tlast,
  output logic                   s01_axis_tready,
  output logic                   m00_axis_tvalid,
  output logic [TDATA_WIDTH-1:0] m00_axis_tdata,
  output logic                   m00_axis_tlast,
  input  logic                   m00_axis_tready,
  output logic [1:0]             grant,
  output logic [PKT_CNT_W-1:0]   pkt_count0,
  output logic [PKT_CNT_W-1:0]   pkt_count1,
  output logic                   err_tlast,
  output logic                   err_timeout
);
  localparam int BW = $clog2(PACKET_COUNT);
  localparam logic [BW-1:0] LAST_BEAT = BW'(PACKET_COUNT - 1);
  arb_state_t state, state_n;
  logic last_served, sel, granted, accept, src_tlast, done, stall_hit, timeout;
  logic [BW-1:0] beat_cnt;
  // the timer is held at zero while idle so every grant starts with a fresh stall budget
  stall_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_stall (
    .clk(axis_aclk),
    .rst(axis_areset),
    .clr(accept | ~granted | stall_hit),
    .en(granted),
    .hit(stall_hit)
  );
  always_comb begin
    sel = state == OWN1;
    granted = state != IDLE;
    grant = {sel, state == OWN0};
    m00_axis_tvalid = sel ? s01_axis_tvalid : (granted & s00_axis_tvalid);
    m00_axis_tdata = sel ? s01_axis_tdata : (granted ? s00_axis_tdata : '0);
    s00_axis_tready = (state == OWN0) & m00_axis_tready;
    s01_axis_tready = sel & m00_axis_tready;
    m00_axis_tlast = granted & (beat_cnt == LAST_BEAT);
    src_tlast = sel ? s01_axis_tlast : s00_axis_tlast;
    accept = m00_axis_tvalid & m00_axis_tready;
    done = accept & m00_axis_tlast;
    // an accepted beat on the threshold cycle always beats the timeout
    timeout = granted & stall_hit & ~accept;
    state_n = state;
    if (!granted && enable && (s00_axis_tvalid || s01_axis_tvalid))
      state_n = next_owner({s01_axis_tvalid, s00_axis_tvalid}, last_served) ? OWN1 : OWN0;
    else if (done || timeout)
      state_n = IDLE;
  end
  always_ff @(posedge axis_aclk or posedge axis_areset)
    if (axis_areset) begin
      state <= IDLE;
      last_served <= 1'b1;
      beat_cnt <= '0;
      pkt_count0 <= '0;
      pkt_count1 <= '0;
      err_tlast <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_n;
      beat_cnt <= (done || timeout) ? '0 : beat_cnt + BW'(accept);
      if (done || timeout) last_served <= sel;
      if (done && !sel) pkt_count0 <= pkt_count0 + PKT_CNT_W'(1);
      if (done && sel) pkt_count1 <= pkt_count1 + PKT_CNT_W'(1);
      if (accept && (src_tlast != m00_axis_tlast)) err_tlast <= 1'b1;
      if (timeout) err_timeout <= 1'b1;
    end
endmodule

// File: tb/tb_packet_arbiter_sv.sv
// tb_packet_arbiter_sv: randomized self-checking bench against a packet-level reference model
module tb_packet_arbiter_sv;
  localparam int DW = 192;
  localparam int PC = 4;
  localparam int TO = 8;
  logic clk = 1'b0, rst = 1'b1, enable;
  logic s00_axis_tvalid, s00_axis_tlast, s00_axis_tready;
  logic s01_axis_tvalid, s01_axis_tlast, s01_axis_tready;
  logic [DW-1:0] s00_axis_tdata, s01_axis_tdata, m00_axis_tdata;
  logic m00_axis_tvalid, m00_axis_tlast, m00_axis_tready;
  logic [1:0] grant;
  logic [15:0] pkt_count0, pkt_count1;
  logic err_tlast, err_timeout;
  packet_arbiter_sv #(.TDATA_WIDTH(DW), .PACKET_COUNT(PC), .TIMEOUT_CYCLES(TO)) dut (
    .axis_aclk(clk), .axis_areset(rst), .enable(enable),
    .s00_axis_tvalid(s00_axis_tvalid), .s00_axis_tdata(s00_axis_tdata),
    .s00_axis_tlast(s00_axis_tlast), .s00_axis_tready(s00_axis_tready),
    .s01_axis_tvalid(s01_axis_tvalid), .s01_axis_tdata(s01_axis_tdata),
    .s01_axis_tlast(s01_axis_tlast), .s01_axis_tready(s01_axis_tready),
    .m00_axis_tvalid(m00_axis_tvalid), .m00_axis_tdata(m00_axis_tdata),
    .m00_axis_tlast(m00_axis_tlast), .m00_axis_tready(m00_axis_tready),
    .grant(grant), .pkt_count0(pkt_count0), .pkt_count1(pkt_count1),
    .err_tlast(err_tlast), .err_timeout(err_timeout)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  // reference model: owner (-1 idle), beats taken in this packet, idle cycles in this grant
  int own, last, beats, stall;
  int cnt[2];
  bit et, eto;
  logic [5:0] ctl, exp_ctl;
  logic [33:0] stat, exp_stat;
  logic [DW-1:0] exp_data;
  assign ctl = {grant, m00_axis_tvalid, m00_axis_tlast, s00_axis_tready, s01_axis_tready};
  assign stat = {pkt_count0, pkt_count1, err_tlast, err_timeout};
  assign exp_stat = {16'(cnt[0]), 16'(cnt[1]), et, eto};
  task automatic model_reset();
    own = -1; last = 1; beats = 0; stall = 0; cnt[0] = 0; cnt[1] = 0; et = 0; eto = 0;
  endtask
  task automatic zero_in();
    enable = 0; m00_axis_tready = 0;
    s00_axis_tvalid = 0; s00_axis_tlast = 0; s00_axis_tdata = '0;
    s01_axis_tvalid = 0; s01_axis_tlast = 0; s01_axis_tdata = '0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1; zero_in();
    @(negedge clk);
    rst = 0; model_reset();
  endtask
  // correct source tlast for source n in the model's current state
  function automatic bit good_last(int n);
    return own == n && beats == PC - 1;
  endfunction
  task automatic drive(input bit v0, v1, l0, l1, en, rdy);
    @(negedge clk);
    for (int i = 0; i < DW / 32; i++) begin
      s00_axis_tdata[i*32 +: 32] = $urandom;
      s01_axis_tdata[i*32 +: 32] = $urandom;
    end
    s00_axis_tvalid = v0; s01_axis_tvalid = v1;
    s00_axis_tlast = l0; s01_axis_tlast = l1;
    enable = en; m00_axis_tready = rdy;
    #1;
    exp_ctl = {own == 1, own == 0, own == 0 ? v0 : (own == 1 ? v1 : 1'b0),
               own >= 0 && beats == PC - 1, own == 0 && rdy, own == 1 && rdy};
    exp_data = own == 0 ? s00_axis_tdata : (own == 1 ? s01_axis_tdata : '0);
  endtask
  // advance the model by one clock using the inputs currently driven, then let the DUT clock
  task automatic tick();
    bit acc, tl, v, l;
    if (own < 0) begin
      if (enable && (s00_axis_tvalid || s01_axis_tvalid)) begin
        own = (s00_axis_tvalid && s01_axis_tvalid) ? 1 - last : (s01_axis_tvalid ? 1 : 0);
        stall = 0;
      end
    end else begin
      v = own == 1 ? s01_axis_tvalid : s00_axis_tvalid;
      l = own == 1 ? s01_axis_tlast : s00_axis_tlast;
      acc = v && m00_axis_tready;
      tl = beats == PC - 1;
      if (acc && l != tl) et = 1;
      if (acc && tl) begin
        cnt[own] = (cnt[own] + 1) % 65536; last = own; beats = 0; own = -1;
      end else if (acc) begin
        beats++; stall = 0;
      end else if (stall == TO - 1) begin
        eto = 1; last = own; beats = 0; own = -1;
      end else stall++;
    end
    @(posedge clk);
  endtask
  task automatic test_reset();
    @(negedge clk);
    rst = 1; zero_in();
    s00_axis_tvalid = 1; s01_axis_tvalid = 1; enable = 1; m00_axis_tready = 1;
    s00_axis_tdata = '1;
    #1;
    checks++; if (ctl !== 6'b0) begin failures++; $display("FAIL reset_ctl got=%b exp=000000", ctl); end
    checks++; if (m00_axis_tdata !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", m00_axis_tdata); end
    checks++; if (stat !== 34'b0) begin failures++; $display("FAIL reset_stat got=%h exp=0", stat); end
    @(negedge clk);
    zero_in(); rst = 0; model_reset();
  endtask
  task automatic test_single_source();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      drive(1, 0, good_last(0), 0, 1, 1);
      checks++; if (ctl !== exp_ctl) begin failures++; $display("FAIL single_ctl c=%0d got=%b exp=%b", c, ctl, exp_ctl); end
      checks++; if (m00_axis_tdata !== exp_data) begin failures++; $display("FAIL single_data c=%0d got=%h exp=%h", c, m00_axis_tdata, exp_data); end
      if (c == 1 || c == 6) begin
        checks++; if (grant !== 2'b01) begin failures++; $display("FAIL single_grant c=%0d got=%b exp=01", c, grant); end
      end
      if (c == 4 || c == 9) begin
        checks++; if (m00_axis_tlast !== 1'b1) begin failures++; $display("FAIL single_tlast c=%0d got=%b exp=1", c, m00_axis_tlast); end
      end
      if (c == 5) begin
        checks++; if (grant !== 2'b00 || pkt_count0 !== 16'd1) begin failures++; $display("FAIL single_gap grant=%b cnt0=%0d exp 00/1", grant, pkt_count0); end
      end
      tick();
    end
    #1;
    checks++; if (pkt_count0 !== 16'd2) begin failures++; $display("FAIL single_count got=%0d exp=2", pkt_count0); end
  endtask
  task automatic test_both_valid();
    logic [1:0] g;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      drive(1, 1, good_last(0), good_last(1), 1, 1);
      g = (c % 5 == 0) ? 2'b00 : (((c / 5) % 2 == 0) ? 2'b01 : 2'b10);
      checks++; if (ctl !== exp_ctl) begin failures++; $display("FAIL both_ctl c=%0d got=%b exp=%b", c, ctl, exp_ctl); end
      checks++; if (grant !== g) begin failures++; $display("FAIL both_grant c=%0d got=%b exp=%b", c, grant, g); end
      tick();
    end
    #1;
    checks++; if (pkt_count0 !== 16'd2 || pkt_count1 !== 16'd2) begin failures++; $display("FAIL both_counts got=%0d/%0d exp=2/2", pkt_count0, pkt_count1); end
  endtask
  task automatic test_toggle_ready();
    int nacc = 0;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      drive(1, 1'($urandom_range(0, 1)), good_last(0), good_last(1), 1, c % 2 == 0);
      checks++; if (ctl !== exp_ctl) begin failures++; $display("FAIL toggle_ctl c=%0d got=%b exp=%b", c, ctl, exp_ctl); end
      checks++; if (m00_axis_tdata !== exp_data) begin failures++; $display("FAIL toggle_data c=%0d got=%h exp=%h", c, m00_axis_tdata, exp_data); end
      if (m00_axis_tvalid && m00_axis_tready) begin
        checks++; if (m00_axis_tlast !== (nacc == PC - 1)) begin failures++; $display("FAIL toggle_tlast c=%0d got=%b beat=%0d", c, m00_axis_tlast, nacc); end
        nacc = (nacc + 1) % PC;
      end
      tick();
    end
  endtask
  task automatic test_tlast_err();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(0, 1, 0, own == 1 && beats == 1, 1, 1);
      checks++; if (ctl !== exp_ctl) begin failures++; $display("FAIL tlerr_ctl c=%0d got=%b exp=%b", c, ctl, exp_ctl); end
      checks++; if (stat !== exp_stat) begin failures++; $display("FAIL tlerr_stat c=%0d got=%h exp=%h", c, stat, exp_stat); end
      tick();
    end
    #1;
    checks++; if (err_tlast !== 1'b1 || pkt_count1 !== 16'd1 || err_timeout !== 1'b0) begin
      failures++; $display("FAIL tlerr_final err=%b cnt1=%0d to=%b exp 1/1/0", err_tlast, pkt_count1, err_timeout); end
  endtask
  task automatic test_timeout();
    do_reset();
    for (int c = 0; c < 14; c++) begin
      drive(c <= 2, 1, good_last(0), good_last(1), 1, 1);
      checks++; if (ctl !== exp_ctl) begin failures++; $display("FAIL timeout_ctl c=%0d got=%b exp=%b", c, ctl, exp_ctl); end
      checks++; if (stat !== exp_stat) begin failures++; $display("FAIL timeout_stat c=%0d got=%h exp=%h", c, stat, exp_stat); end
      if (c == 10) begin
        checks++; if (grant !== 2'b01 || err_timeout !== 1'b0) begin failures++; $display("FAIL timeout_edge grant=%b err=%b exp 01/0", grant, err_timeout); end
      end
      if (c == 11) begin
        checks++; if (grant !== 2'b00 || err_timeout !== 1'b1) begin failures++; $display("FAIL timeout_drop grant=%b err=%b exp 00/1", grant, err_timeout); end
      end
      if (c == 12) begin
        checks++; if (grant !== 2'b10) begin failures++; $display("FAIL timeout_next grant=%b exp=10", grant); end
      end
      tick();
    end
    #1;
    checks++; if (pkt_count0 !== 16'd0) begin failures++; $display("FAIL timeout_count got=%0d exp=0", pkt_count0); end
  endtask
  task automatic test_last_vs_timeout();
    do_reset();
    for (int c = 0; c < 13; c++) begin
      drive(c <= 3 || c == 11, 0, good_last(0), 0, 1, 1);
      checks++; if (ctl !== exp_ctl) begin failures++; $display("FAIL race_ctl c=%0d got=%b exp=%b", c, ctl, exp_ctl); end
      if (c == 11) begin
        checks++; if (m00_axis_tlast !== 1'b1) begin failures++; $display("FAIL race_tlast got=%b exp=1", m00_axis_tlast); end
      end
      tick();
    end
    #1;
    checks++; if (err_timeout !== 1'b0 || pkt_count0 !== 16'd1) begin failures++; $display("FAIL race_final err=%b cnt0=%0d exp 0/1", err_timeout, pkt_count0); end
  endtask
  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(1, 1, good_last(0), good_last(1), 1, 1);
      checks++; if (ctl !== exp_ctl) begin failures++; $display("FAIL rmid_ctl c=%0d got=%b exp=%b", c, ctl, exp_ctl); end
      if (c < 3) tick();
    end
    #1 rst = 1;
    #1;
    checks++; if (ctl !== 6'b0 || m00_axis_tdata !== '0) begin failures++; $display("FAIL rmid_async ctl=%b data=%h exp 0", ctl, m00_axis_tdata); end
    @(negedge clk);
    zero_in(); rst = 0; model_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1, 1, good_last(0), good_last(1), 1, 1);
      if (c == 1) begin
        checks++; if (grant !== 2'b01) begin failures++; $display("FAIL rmid_regrant got=%b exp=01", grant); end
      end
      tick();
    end
  endtask
  task automatic test_random();
    int p0 = 5, p1 = 5;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) begin p0 = $urandom_range(0, 10); p1 = $urandom_range(0, 10); end
      drive($urandom_range(0, 9) < p0, $urandom_range(0, 9) < p1,
            good_last(0) ^ ($urandom_range(0, 63) == 0), good_last(1) ^ ($urandom_range(0, 63) == 0),
            $urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0);
      checks++; if (ctl !== exp_ctl) begin failures++; $display("FAIL rand_ctl c=%0d got=%b exp=%b", c, ctl, exp_ctl); end
      checks++; if (m00_axis_tdata !== exp_data) begin failures++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, m00_axis_tdata, exp_data); end
      checks++; if (stat !== exp_stat) begin failures++; $display("FAIL rand_stat c=%0d got=%h exp=%h", c, stat, exp_stat); end
      tick();
    end
  endtask
  initial begin
    zero_in();
    model_reset();
    test_reset();
    test_single_source();
    test_both_valid();
    test_toggle_ready();
    test_tlast_err();
    test_timeout();
    test_last_vs_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
